assoc_hashmap: RTL and testbench

//  Set-associative key/value cache: SETS sets of WAYS entries, indexed by key % SETS.

---
 rtl/hashmap_pkg.sv | 20 ++
 rtl/hashmap_set_match.sv | 35 +++
 rtl/assoc_hashmap.sv | 186 ++++++++++++++++++
 tb/tb_assoc_hashmap.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hashmap_pkg.sv
// Shared types and helpers for the set-associative key/value cache.
package hashmap_pkg;

  // Sweep controller states.
  typedef enum logic {
    StIdle  = 1'b0,
    StClear = 1'b1
  } state_e;

  // Set index for a key; keys are zero-extended to 64 bits before the modulo.
  function automatic int unsigned hash_key(input logic [63:0] key, input int unsigned sets);
    return 32'(key % 64'(sets));
  endfunction

  // Width needed to hold an occupancy count from 0 up to and including entries.
  function automatic int unsigned cnt_width(input int unsigned entries);
    return $clog2(entries + 1);
  endfunction

endpackage

// File: rtl/hashmap_set_match.sv
// Combinational tag compare across all ways of one set.
module hashmap_set_match
  import hashmap_pkg::*;
#(
  parameter int unsigned KEY_WIDTH = 8,
  parameter int unsigned WAYS      = 2,
  localparam int unsigned WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic [KEY_WIDTH-1:0]      i_key,
  input  logic [WAYS-1:0]           i_valid,
  input  logic [WAYS*KEY_WIDTH-1:0] i_keys,
  output logic                      o_hit,
  output logic [WAY_W-1:0]          o_hit_way,
  output logic [WAY_W-1:0]          o_free_way,
  output logic                      o_full
);

  // Walk ways from the top down so the lowest-index hit and free way win.
  always_comb begin
    o_hit      = 1'b0;
    o_hit_way  = '0;
    o_free_way = '0;
    o_full     = &i_valid;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!i_valid[w]) begin
        o_free_way = WAY_W'(w);
      end
      if (i_valid[w] && (i_keys[w*KEY_WIDTH +: KEY_WIDTH] == i_key)) begin
        o_hit     = 1'b1;
        o_hit_way = WAY_W'(w);
      end
    end
  end

endmodule

// File: rtl/assoc_hashmap.sv
// Set-associative key/value cache with round-robin eviction, delete, registered
// read port, occupancy counter and a one-set-per-cycle clear sweep.
module assoc_hashmap
  import hashmap_pkg::*;
#(
  parameter int unsigned KEY_WIDTH   = 8,
  parameter int unsigned VALUE_WIDTH = 8,
  parameter int unsigned SETS        = 4,
  parameter int unsigned WAYS        = 2,
  parameter int unsigned OVERWRITE   = 1
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_wr_valid,
  output logic                               o_wr_ready,
  input  logic [KEY_WIDTH-1:0]               i_wr_key,
  input  logic [VALUE_WIDTH-1:0]             i_wr_value,
  output logic                               o_wr_hit,
  output logic                               o_wr_evict,
  output logic                               o_wr_drop,
  input  logic                               i_rd_valid,
  input  logic [KEY_WIDTH-1:0]               i_rd_key,
  output logic                               o_rd_resp_valid,
  output logic                               o_rd_hit,
  output logic [VALUE_WIDTH-1:0]             o_rd_value,
  input  logic                               i_del_valid,
  input  logic [KEY_WIDTH-1:0]               i_del_key,
  output logic                               o_del_hit,
  input  logic                               i_clear,
  output logic                               o_busy,
  output logic [cnt_width(SETS*WAYS)-1:0]    o_count
);

  localparam int unsigned SET_W = $clog2(SETS);
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned CNT_W = cnt_width(SETS * WAYS);

  state_e                           r_state, w_state_next;
  logic [SET_W-1:0]                 r_clr_set;
  logic [WAYS-1:0]                  r_valid [SETS];
  logic [WAYS-1:0][KEY_WIDTH-1:0]   r_key   [SETS];
  logic [WAYS-1:0][VALUE_WIDTH-1:0] r_value [SETS];
  logic [WAY_W-1:0]                 r_rr    [SETS];
  logic [CNT_W-1:0]                 r_count;
  logic                             r_wr_hit, r_wr_evict, r_wr_drop, r_del_hit;
  logic                             r_rd_resp_valid, r_rd_hit;
  logic [VALUE_WIDTH-1:0]           r_rd_value;

  logic             w_busy, w_wr_fire, w_del_fire;
  logic [SET_W-1:0] w_wr_set, w_rd_set, w_del_set;
  logic             w_wr_hit, w_wr_full, w_rd_hit, w_del_hit;
  logic [WAY_W-1:0] w_wr_hit_way, w_wr_free, w_wr_way, w_rd_way, w_del_way;
  logic [WAY_W-1:0] w_unused_rd_free, w_unused_del_free;
  logic             w_unused_rd_full, w_unused_del_full;

  assign w_busy     = (r_state == StClear);
  // Gated by reset so every output reads 0 while reset is held.
  assign o_wr_ready = i_rst_n && !w_busy && !i_del_valid;
  assign w_wr_fire  = i_wr_valid && o_wr_ready;
  assign w_del_fire = i_del_valid && !w_busy;

  assign w_wr_set  = SET_W'(hash_key(64'(i_wr_key), SETS));
  assign w_rd_set  = SET_W'(hash_key(64'(i_rd_key), SETS));
  assign w_del_set = SET_W'(hash_key(64'(i_del_key), SETS));
  assign w_wr_way  = w_wr_full ? r_rr[w_wr_set] : w_wr_free;

  hashmap_set_match #(.KEY_WIDTH(KEY_WIDTH), .WAYS(WAYS)) u_wr_match (
    .i_key      (i_wr_key),
    .i_valid    (r_valid[w_wr_set]),
    .i_keys     (r_key[w_wr_set]),
    .o_hit      (w_wr_hit),
    .o_hit_way  (w_wr_hit_way),
    .o_free_way (w_wr_free),
    .o_full     (w_wr_full)
  );

  hashmap_set_match #(.KEY_WIDTH(KEY_WIDTH), .WAYS(WAYS)) u_rd_match (
    .i_key      (i_rd_key),
    .i_valid    (r_valid[w_rd_set]),
    .i_keys     (r_key[w_rd_set]),
    .o_hit      (w_rd_hit),
    .o_hit_way  (w_rd_way),
    .o_free_way (w_unused_rd_free),
    .o_full     (w_unused_rd_full)
  );

  hashmap_set_match #(.KEY_WIDTH(KEY_WIDTH), .WAYS(WAYS)) u_del_match (
    .i_key      (i_del_key),
    .i_valid    (r_valid[w_del_set]),
    .i_keys     (r_key[w_del_set]),
    .o_hit      (w_del_hit),
    .o_hit_way  (w_del_way),
    .o_free_way (w_unused_del_free),
    .o_full     (w_unused_del_full)
  );

  // Sweep state register and set cursor.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_clr_set <= '0;
    end else begin
      r_state   <= w_state_next;
      r_clr_set <= w_busy ? r_clr_set + 1'b1 : '0;
    end
  end

  // Next-state: one sweep cycle per set, leaving after the last set.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_clear) w_state_next = StClear;
      StClear: if (r_clr_set == SET_W'(SETS - 1)) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Valid bits, eviction pointers and occupancy; sweep, write and delete are exclusive.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_rr[s]    <= '0;
      end
      r_count <= '0;
    end else if (w_busy) begin
      r_valid[r_clr_set] <= '0;
      r_rr[r_clr_set]    <= '0;
      if (r_clr_set == '0) r_count <= '0;
    end else if (w_wr_fire && !w_wr_hit) begin
      r_valid[w_wr_set][w_wr_way] <= 1'b1;
      if (w_wr_full) begin
        r_rr[w_wr_set] <= (r_rr[w_wr_set] == WAY_W'(WAYS - 1)) ? '0 : r_rr[w_wr_set] + 1'b1;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end else if (w_del_fire && w_del_hit) begin
      r_valid[w_del_set][w_del_way] <= 1'b0;
      r_count                       <= r_count - 1'b1;
    end
  end

  // Key/value payload needs no reset; valid bits qualify it.
  always_ff @(posedge i_clk) begin
    if (w_wr_fire) begin
      if (w_wr_hit) begin
        if (OVERWRITE != 0) r_value[w_wr_set][w_wr_hit_way] <= i_wr_value;
      end else begin
        r_key[w_wr_set][w_wr_way]   <= i_wr_key;
        r_value[w_wr_set][w_wr_way] <= i_wr_value;
      end
    end
  end

  // Status pulses and registered read response, all from pre-update state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_hit        <= 1'b0;
      r_wr_evict      <= 1'b0;
      r_wr_drop       <= 1'b0;
      r_del_hit       <= 1'b0;
      r_rd_resp_valid <= 1'b0;
      r_rd_hit        <= 1'b0;
      r_rd_value      <= '0;
    end else begin
      r_wr_hit        <= w_wr_fire && w_wr_hit;
      r_wr_evict      <= w_wr_fire && !w_wr_hit && w_wr_full;
      r_wr_drop       <= w_wr_fire && w_wr_hit && (OVERWRITE == 0);
      r_del_hit       <= w_del_fire && w_del_hit;
      r_rd_resp_valid <= i_rd_valid;
      r_rd_hit        <= i_rd_valid && !w_busy && w_rd_hit;
      r_rd_value      <= (i_rd_valid && !w_busy && w_rd_hit) ? r_value[w_rd_set][w_rd_way] : '0;
    end
  end

  assign o_wr_hit        = r_wr_hit;
  assign o_wr_evict      = r_wr_evict;
  assign o_wr_drop       = r_wr_drop;
  assign o_del_hit       = r_del_hit;
  assign o_rd_resp_valid = r_rd_resp_valid;
  assign o_rd_hit        = r_rd_hit;
  assign o_rd_value      = r_rd_value;
  assign o_busy          = w_busy;
  assign o_count         = r_count;

endmodule

// File: tb/tb_assoc_hashmap.sv
// Directed bench for assoc_hashmap: SETS=4, WAYS=2, 8-bit keys/values, plus an
// OVERWRITE=0 instance for the drop behaviour.
module tb_assoc_hashmap;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid, rd_valid, del_valid, clear;
  logic [7:0] wr_key, wr_value, rd_key, del_key;
  logic       wr_ready, wr_hit, wr_evict, wr_drop, rd_resp_valid, rd_hit, del_hit, busy;
  logic [7:0] rd_value;
  logic [3:0] count;

  logic       n_wr_valid, n_rd_valid;
  logic [7:0] n_wr_key, n_wr_value, n_rd_key;
  logic       n_wr_ready, n_wr_hit, n_wr_evict, n_wr_drop, n_rd_resp_valid, n_rd_hit;
  logic       n_del_hit, n_busy;
  logic [7:0] n_rd_value;
  logic [3:0] n_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assoc_hashmap #(.KEY_WIDTH(8), .VALUE_WIDTH(8), .SETS(4), .WAYS(2), .OVERWRITE(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_key(wr_key), .i_wr_value(wr_value),
    .o_wr_hit(wr_hit), .o_wr_evict(wr_evict), .o_wr_drop(wr_drop),
    .i_rd_valid(rd_valid), .i_rd_key(rd_key), .o_rd_resp_valid(rd_resp_valid),
    .o_rd_hit(rd_hit), .o_rd_value(rd_value),
    .i_del_valid(del_valid), .i_del_key(del_key), .o_del_hit(del_hit),
    .i_clear(clear), .o_busy(busy), .o_count(count)
  );

  assoc_hashmap #(.KEY_WIDTH(8), .VALUE_WIDTH(8), .SETS(4), .WAYS(2), .OVERWRITE(0)) dut_nk (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_valid(n_wr_valid), .o_wr_ready(n_wr_ready), .i_wr_key(n_wr_key),
    .i_wr_value(n_wr_value), .o_wr_hit(n_wr_hit), .o_wr_evict(n_wr_evict), .o_wr_drop(n_wr_drop),
    .i_rd_valid(n_rd_valid), .i_rd_key(n_rd_key), .o_rd_resp_valid(n_rd_resp_valid),
    .o_rd_hit(n_rd_hit), .o_rd_value(n_rd_value),
    .i_del_valid(1'b0), .i_del_key(8'h00), .o_del_hit(n_del_hit),
    .i_clear(1'b0), .o_busy(n_busy), .o_count(n_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    wr_valid = 0; rd_valid = 0; del_valid = 0; clear = 0;
    wr_key = 0; wr_value = 0; rd_key = 0; del_key = 0;
    n_wr_valid = 0; n_rd_valid = 0; n_wr_key = 0; n_wr_value = 0; n_rd_key = 0;
    #7;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic do_write(input logic [7:0] k, input logic [7:0] v);
    wr_valid = 1'b1; wr_key = k; wr_value = v;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] k);
    rd_valid = 1'b1; rd_key = k;
    step();
    rd_valid = 1'b0;
  endtask

  task automatic do_del(input logic [7:0] k);
    del_valid = 1'b1; del_key = k;
    step();
    del_valid = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (rd_resp_valid !== 1'b0) begin
      bad++; $display("FAIL reset_rd_resp got=%b want=0", rd_resp_valid);
    end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%b want=1", wr_ready); end
  endtask

  task automatic test_write_read();
    do_write(8'h05, 8'h33);
    total++; if (wr_hit !== 1'b0 || wr_evict !== 1'b0) begin
      bad++; $display("FAIL wr1_flags got=%b%b want=00", wr_hit, wr_evict);
    end
    total++; if (count !== 4'd1) begin bad++; $display("FAIL wr1_count got=%0d want=1", count); end
    do_read(8'h05);
    total++; if (rd_resp_valid !== 1'b1 || rd_hit !== 1'b1 || rd_value !== 8'h33) begin
      bad++; $display("FAIL rd1 got=v%b h%b %h want=v1 h1 33", rd_resp_valid, rd_hit, rd_value);
    end
  endtask

  task automatic test_evict();
    reset_dut();
    do_write(8'h01, 8'h11);
    do_write(8'h05, 8'h55);
    total++; if (count !== 4'd2) begin bad++; $display("FAIL ev_fill_count got=%0d want=2", count); end
    do_write(8'h09, 8'h99);
    total++; if (wr_evict !== 1'b1 || wr_hit !== 1'b0) begin
      bad++; $display("FAIL ev_flags got=e%b h%b want=e1 h0", wr_evict, wr_hit);
    end
    total++; if (count !== 4'd2) begin bad++; $display("FAIL ev_count got=%0d want=2", count); end
    do_read(8'h01);
    total++; if (rd_hit !== 1'b0 || rd_value !== 8'h00) begin
      bad++; $display("FAIL ev_rd01 got=h%b %h want=h0 00", rd_hit, rd_value);
    end
    do_read(8'h09);
    total++; if (rd_hit !== 1'b1 || rd_value !== 8'h99) begin
      bad++; $display("FAIL ev_rd09 got=h%b %h want=h1 99", rd_hit, rd_value);
    end
  endtask

  task automatic test_overwrite();
    do_write(8'h05, 8'h77);
    total++; if (wr_hit !== 1'b1 || wr_drop !== 1'b0 || wr_evict !== 1'b0) begin
      bad++; $display("FAIL ow_flags got=h%b d%b e%b want=h1 d0 e0", wr_hit, wr_drop, wr_evict);
    end
    total++; if (count !== 4'd2) begin bad++; $display("FAIL ow_count got=%0d want=2", count); end
    do_read(8'h05);
    total++; if (rd_hit !== 1'b1 || rd_value !== 8'h77) begin
      bad++; $display("FAIL ow_rd got=h%b %h want=h1 77", rd_hit, rd_value);
    end
    // Keep-first instance: second write of the same key is dropped.
    n_wr_valid = 1'b1; n_wr_key = 8'h05; n_wr_value = 8'h33;
    step();
    n_wr_value = 8'h77;
    step();
    n_wr_valid = 1'b0;
    total++; if (n_wr_hit !== 1'b1 || n_wr_drop !== 1'b1) begin
      bad++; $display("FAIL nk_flags got=h%b d%b want=h1 d1", n_wr_hit, n_wr_drop);
    end
    total++; if (n_count !== 4'd1) begin bad++; $display("FAIL nk_count got=%0d want=1", n_count); end
    n_rd_valid = 1'b1; n_rd_key = 8'h05;
    step();
    n_rd_valid = 1'b0;
    total++; if (n_rd_hit !== 1'b1 || n_rd_value !== 8'h33) begin
      bad++; $display("FAIL nk_rd got=h%b %h want=h1 33", n_rd_hit, n_rd_value);
    end
  endtask

  task automatic test_delete();
    do_del(8'h09);
    total++; if (del_hit !== 1'b1) begin bad++; $display("FAIL del09_hit got=%b want=1", del_hit); end
    total++; if (count !== 4'd1) begin bad++; $display("FAIL del09_count got=%0d want=1", count); end
    do_read(8'h09);
    total++; if (rd_hit !== 1'b0) begin bad++; $display("FAIL del09_rd got=%b want=0", rd_hit); end
    do_del(8'h0D);
    total++; if (del_hit !== 1'b0) begin bad++; $display("FAIL del0d_hit got=%b want=0", del_hit); end
    total++; if (count !== 4'd1) begin bad++; $display("FAIL del0d_count got=%0d want=1", count); end
  endtask

  task automatic test_back_to_back();
    // Same-cycle write and delete: delete wins, write is not accepted.
    wr_valid = 1'b1; wr_key = 8'h22; wr_value = 8'h5A;
    del_valid = 1'b1; del_key = 8'h05;
    #1;
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL wd_ready got=%b want=0", wr_ready); end
    step();
    wr_valid = 1'b0; del_valid = 1'b0;
    total++; if (del_hit !== 1'b1 || wr_hit !== 1'b0 || wr_evict !== 1'b0) begin
      bad++; $display("FAIL wd_flags got=d%b h%b e%b want=d1 h0 e0", del_hit, wr_hit, wr_evict);
    end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL wd_count got=%0d want=0", count); end
    do_read(8'h22);
    total++; if (rd_hit !== 1'b0) begin bad++; $display("FAIL wd_rd22 got=%b want=0", rd_hit); end
    // Set 1 pointer is at way 1 after the earlier eviction, then wraps to way 0.
    do_write(8'h01, 8'h01);
    do_write(8'h0D, 8'h0D);
    do_write(8'h11, 8'h11);
    total++; if (wr_evict !== 1'b1 || count !== 4'd2) begin
      bad++; $display("FAIL rr1 got=e%b c%0d want=e1 c2", wr_evict, count);
    end
    do_read(8'h0D);
    total++; if (rd_hit !== 1'b0) begin bad++; $display("FAIL rr1_rd0d got=%b want=0", rd_hit); end
    do_read(8'h01);
    total++; if (rd_hit !== 1'b1 || rd_value !== 8'h01) begin
      bad++; $display("FAIL rr1_rd01 got=h%b %h want=h1 01", rd_hit, rd_value);
    end
    do_write(8'h15, 8'h15);
    do_read(8'h01);
    total++; if (rd_hit !== 1'b0) begin bad++; $display("FAIL rr2_rd01 got=%b want=0", rd_hit); end
    do_read(8'h11);
    total++; if (rd_hit !== 1'b1 || rd_value !== 8'h11) begin
      bad++; $display("FAIL rr2_rd11 got=h%b %h want=h1 11", rd_hit, rd_value);
    end
    // Read in the same cycle as a write sees the old state; the next cycle sees the new.
    wr_valid = 1'b1; wr_key = 8'h06; wr_value = 8'h66;
    rd_valid = 1'b1; rd_key = 8'h06;
    step();
    wr_valid = 1'b0;
    total++; if (rd_resp_valid !== 1'b1 || rd_hit !== 1'b0) begin
      bad++; $display("FAIL nobypass got=v%b h%b want=v1 h0", rd_resp_valid, rd_hit);
    end
    step();
    rd_valid = 1'b0;
    total++; if (rd_hit !== 1'b1 || rd_value !== 8'h66) begin
      bad++; $display("FAIL nextrd got=h%b %h want=h1 66", rd_hit, rd_value);
    end
  endtask

  task automatic test_clear();
    do_write(8'h03, 8'h30);
    total++; if (count !== 4'd4) begin bad++; $display("FAIL clr_pre_count got=%0d want=4", count); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL clr_busy%0d got=%b want=1", i, busy); end
      wr_valid = 1'b1; wr_key = 8'h04; wr_value = 8'h44;
      rd_valid = 1'b1; rd_key = 8'h03;
      #1;
      total++; if (wr_ready !== 1'b0) begin
        bad++; $display("FAIL clr_ready%0d got=%b want=0", i, wr_ready);
      end
      step();
      total++; if (rd_resp_valid !== 1'b1 || rd_hit !== 1'b0 || rd_value !== 8'h00) begin
        bad++; $display("FAIL clr_rd%0d got=v%b h%b %h want=v1 h0 00", i, rd_resp_valid, rd_hit,
                        rd_value);
      end
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL clr_done_busy got=%b want=0", busy); end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL clr_count got=%0d want=0", count); end
    do_read(8'h15);
    total++; if (rd_hit !== 1'b0) begin bad++; $display("FAIL clr_rd15 got=%b want=0", rd_hit); end
    do_read(8'h06);
    total++; if (rd_hit !== 1'b0) begin bad++; $display("FAIL clr_rd06 got=%b want=0", rd_hit); end
    do_read(8'h04);
    total++; if (rd_hit !== 1'b0) begin bad++; $display("FAIL clr_rd04 got=%b want=0", rd_hit); end
  endtask

  task automatic test_async_reset();
    do_write(8'h07, 8'h70);
    do_write(8'h07, 8'h71);
    total++; if (wr_hit !== 1'b1 || count !== 4'd1) begin
      bad++; $display("FAIL ar_pre got=h%b c%0d want=h1 c1", wr_hit, count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (wr_hit !== 1'b0 || count !== 4'd0 || wr_ready !== 1'b0) begin
      bad++; $display("FAIL ar_mid got=h%b c%0d r%b want=h0 c0 r0", wr_hit, count, wr_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    do_write(8'h02, 8'h20);
    clear = 1'b1;
    step();
    clear = 1'b0;
    total++; if (busy !== 1'b1 || count !== 4'd1) begin
      bad++; $display("FAIL ar_sweep got=b%b c%0d want=b1 c1", busy, count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || count !== 4'd0 || rd_resp_valid !== 1'b0) begin
      bad++; $display("FAIL ar_clr got=b%b c%0d v%b want=b0 c0 v0", busy, count, rd_resp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    do_read(8'h02);
    total++; if (rd_hit !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL ar_after got=h%b b%b want=h0 b0", rd_hit, busy);
    end
    do_read(8'h07);
    total++; if (rd_hit !== 1'b0) begin bad++; $display("FAIL ar_rd07 got=%b want=0", rd_hit); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_dut();
    test_reset();
    test_write_read();
    test_evict();
    test_overwrite();
    test_delete();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
